// File: rtl/red_pitaya_asg_seq.sv
// Segment sequencer for one double-buffered ASG channel.
// Holds a table of waveform segment descriptors, primes both channel
// configuration banks, then refills whichever bank the channel vacates at
// each bank switch so segment chains play back-to-back, once or looped.
module red_pitaya_asg_seq #(
  parameter int RSZ  = 14,
  parameter int NSEG = 8,
  parameter int SW   = 3,
  parameter int DW   = 44 + 3*(RSZ+16)
) (
  input  logic          dac_clk_i,
  input  logic          dac_rst_i,
  input  logic          seg_we_i,
  input  logic [SW-1:0] seg_idx_i,
  input  logic [DW-1:0] seg_desc_i,
  input  logic          seq_start_i,
  input  logic          seq_stop_i,
  input  logic [SW:0]   seq_len_i,
  input  logic          seq_loop_i,
  input  logic          ch_buf_i,
  output logic [DW-1:0] bank0_o,
  output logic [DW-1:0] bank1_o,
  output logic          ch_rst_o,
  output logic          ch_trig_o,
  output logic          seq_busy_o,
  output logic [SW-1:0] seq_idx_o,
  output logic          seq_done_o,
  output logic          seq_werr_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRIME0 = 3'd1,
    S_PRIME1 = 3'd2,
    S_ARM    = 3'd3,
    S_RUN    = 3'd4
  } state_t;

  localparam logic [SW:0] NSEG_L = (SW+1)'(NSEG);

  state_t        state;
  logic [DW-1:0] tbl [NSEG];
  logic [DW-1:0] rd_data_p1;
  logic [SW-1:0] rd_addr;
  logic [SW-1:0] ld_idx;
  logic [SW-1:0] play_idx;
  logic [SW:0]   len_q;
  logic [SW:0]   played;
  logic          loop_q;
  logic          ch_buf_q;
  logic          toggle;
  logic          tbl_we;
  logic          arm_q;
  logic          done_q;
  logic          rl_vld_p0;
  logic          rl_vld_p1;
  logic          rl_bank_p0;
  logic          rl_bank_p1;

  // Index increment that wraps at the chain length rather than at NSEG.
  function automatic logic [SW-1:0] nxt(input logic [SW-1:0] i, input logic [SW:0] l);
    logic [SW:0] s;
    s = {1'b0, i} + (SW+1)'(1);
    return (s == l) ? '0 : s[SW-1:0];
  endfunction

  assign toggle = ch_buf_i ^ ch_buf_q;
  assign tbl_we = seg_we_i && (state == S_IDLE);

  // Descriptor table: writes only while idle, 1-cycle synchronous read;
  // also tracks the channel's bank to detect switches.
  always_ff @(posedge dac_clk_i) begin
    ch_buf_q   <= ch_buf_i;
    rd_data_p1 <= tbl[rd_addr];
    if (tbl_we) tbl[seg_idx_i] <= seg_desc_i;
  end

  // Sequencer FSM with registered outputs; outputs follow the state one
  // cycle later, and bank refills travel through a two-stage pipeline
  // (address issue -> table read -> bank write).
  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state      <= S_IDLE;
      bank0_o    <= '0;
      bank1_o    <= '0;
      ch_rst_o   <= 1'b1;
      ch_trig_o  <= 1'b0;
      seq_busy_o <= 1'b0;
      seq_idx_o  <= '0;
      seq_done_o <= 1'b0;
      seq_werr_o <= 1'b0;
      play_idx   <= '0;
      arm_q      <= 1'b0;
      done_q     <= 1'b0;
      rl_vld_p0  <= 1'b0;
      rl_vld_p1  <= 1'b0;
    end else begin
      seq_busy_o <= (state != S_IDLE);
      ch_rst_o   <= (state != S_RUN);
      ch_trig_o  <= arm_q;
      seq_done_o <= done_q;
      seq_idx_o  <= play_idx;
      arm_q      <= 1'b0;
      done_q     <= 1'b0;

      // refill stage p0 -> p1: table read in flight; a stop cancels it
      rl_vld_p0  <= 1'b0;
      rl_vld_p1  <= rl_vld_p0 && !seq_stop_i;
      rl_bank_p1 <= rl_bank_p0;

      // refill stage p1 -> bank: write the vacated bank
      if (rl_vld_p1 && !seq_stop_i) begin
        if (rl_bank_p1) bank1_o <= rd_data_p1;
        else            bank0_o <= rd_data_p1;
      end

      if (seg_we_i && (state != S_IDLE)) seq_werr_o <= 1'b1;

      if (seq_stop_i && (state != S_IDLE)) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (seq_start_i && !seq_stop_i && (seq_len_i != '0)) begin
              len_q      <= (seq_len_i > NSEG_L) ? NSEG_L : seq_len_i;
              loop_q     <= seq_loop_i;
              rd_addr    <= '0;
              play_idx   <= '0;
              played     <= '0;
              seq_werr_o <= 1'b0;
              state      <= S_PRIME0;
            end
          end
          S_PRIME0: begin
            rd_addr <= nxt(rd_addr, len_q);
            state   <= S_PRIME1;
          end
          S_PRIME1: begin
            bank0_o <= rd_data_p1;
            ld_idx  <= nxt(rd_addr, len_q);
            state   <= S_ARM;
          end
          S_ARM: begin
            bank1_o <= rd_data_p1;
            arm_q   <= 1'b1;
            state   <= S_RUN;
          end
          S_RUN: begin
            if (toggle) begin
              if (!loop_q && ((played + (SW+1)'(1)) == len_q)) begin
                done_q <= 1'b1;
                state  <= S_IDLE;
              end else begin
                if (!loop_q) played <= played + (SW+1)'(1);
                rd_addr    <= ld_idx;
                ld_idx     <= nxt(ld_idx, len_q);
                play_idx   <= nxt(play_idx, len_q);
                rl_vld_p0  <= 1'b1;
                rl_bank_p0 <= ch_buf_q;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_asg_seq.sv
// Self-checking bench for red_pitaya_asg_seq: stimulus tasks push expected
// output changes (signal, cycle, value) into a queue; a monitor on the
// falling edge pops and compares every observed output change.
module tb_red_pitaya_asg_seq;
  localparam int RSZ  = 14;
  localparam int NSEG = 8;
  localparam int SW   = 3;
  localparam int DW   = 44 + 3*(RSZ+16);

  localparam int K_B0 = 0, K_B1 = 1, K_RST = 2, K_TRIG = 3;
  localparam int K_BUSY = 4, K_IDX = 5, K_DONE = 6, K_WERR = 7, NK = 8;

  logic          clk = 1'b0;
  logic          dac_rst_i = 1'b1;
  logic          seg_we_i = 1'b0;
  logic [SW-1:0] seg_idx_i = '0;
  logic [DW-1:0] seg_desc_i = '0;
  logic          seq_start_i = 1'b0;
  logic          seq_stop_i = 1'b0;
  logic [SW:0]   seq_len_i = '0;
  logic          seq_loop_i = 1'b0;
  logic          ch_buf_i = 1'b0;
  logic [DW-1:0] bank0_o, bank1_o;
  logic          ch_rst_o, ch_trig_o, seq_busy_o, seq_done_o, seq_werr_o;
  logic [SW-1:0] seq_idx_o;

  red_pitaya_asg_seq #(.RSZ(RSZ), .NSEG(NSEG), .SW(SW), .DW(DW)) dut (
    .dac_clk_i(clk), .dac_rst_i(dac_rst_i),
    .seg_we_i(seg_we_i), .seg_idx_i(seg_idx_i), .seg_desc_i(seg_desc_i),
    .seq_start_i(seq_start_i), .seq_stop_i(seq_stop_i),
    .seq_len_i(seq_len_i), .seq_loop_i(seq_loop_i), .ch_buf_i(ch_buf_i),
    .bank0_o(bank0_o), .bank1_o(bank1_o), .ch_rst_o(ch_rst_o),
    .ch_trig_o(ch_trig_o), .seq_busy_o(seq_busy_o), .seq_idx_o(seq_idx_o),
    .seq_done_o(seq_done_o), .seq_werr_o(seq_werr_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            kind;
    int            cyc;
    logic [DW-1:0] val;
  } ev_t;

  ev_t   expq[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  bit    mon_en = 1'b0;
  string knames [NK] = '{"bank0", "bank1", "ch_rst", "ch_trig",
                         "busy", "seq_idx", "done", "werr"};

  // Reference model: table contents and the chain as the channel sees it.
  logic [DW-1:0] m_tbl [NSEG];
  logic [DW-1:0] m_bank [2];
  bit            m_run, m_loop, m_werr;
  int            m_len, m_pl, m_nx, m_played;

  task automatic push(int k, int c, logic [DW-1:0] v);
    ev_t e;
    e.kind = k; e.cyc = c; e.val = v;
    expq.push_back(e);
  endtask

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic match_ev(int k, logic [DW-1:0] v);
    int idx;
    idx = -1;
    foreach (expq[j]) if (idx < 0 && expq[j].kind == k) idx = j;
    n_cmp++;
    if (idx < 0) begin
      n_fail++;
      $display("FAIL %s: unexpected change to %h at cycle %0d", knames[k], v, cyc);
    end else begin
      if (expq[idx].cyc != cyc || expq[idx].val !== v) begin
        n_fail++;
        $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
                 knames[k], v, cyc, expq[idx].val, expq[idx].cyc);
      end
      expq.delete(idx);
    end
  endtask

  task automatic check_empty(string tag);
    n_cmp++;
    if (expq.size() != 0) begin
      n_fail++;
      foreach (expq[j])
        $display("FAIL %s: missing %s change to %h expected at cycle %0d",
                 tag, knames[expq[j].kind], expq[j].val, expq[j].cyc);
      expq.delete();
    end
  endtask

  // Monitor: every output change must match the next expected change.
  logic [DW-1:0] prev [NK];
  logic [DW-1:0] cur  [NK];
  always @(negedge clk) begin
    cur[K_B0]   = bank0_o;
    cur[K_B1]   = bank1_o;
    cur[K_RST]  = DW'(ch_rst_o);
    cur[K_TRIG] = DW'(ch_trig_o);
    cur[K_BUSY] = DW'(seq_busy_o);
    cur[K_IDX]  = DW'(seq_idx_o);
    cur[K_DONE] = DW'(seq_done_o);
    cur[K_WERR] = DW'(seq_werr_o);
    if (mon_en)
      for (int i = 0; i < NK; i++)
        if (cur[i] !== prev[i]) match_ev(i, cur[i]);
    for (int i = 0; i < NK; i++) prev[i] = cur[i];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(int n);
    repeat (n) tick();
  endtask

  function automatic logic [DW-1:0] rnd_desc();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  task automatic set_bank(int b, logic [DW-1:0] v, int c);
    if (m_bank[b] !== v) begin
      push((b == 0) ? K_B0 : K_B1, c, v);
      m_bank[b] = v;
    end
  endtask

  task automatic wr(int idx, logic [DW-1:0] d);
    seg_we_i = 1'b1; seg_idx_i = idx[SW-1:0]; seg_desc_i = d;
    if (!m_run) m_tbl[idx] = d;
    else if (!m_werr) begin
      push(K_WERR, cyc + 1, 1);
      m_werr = 1'b1;
    end
    tick();
    seg_we_i = 1'b0;
  endtask

  task automatic do_start(int len, bit lp, bit with_stop);
    int k;
    k = cyc + 1;
    seq_start_i = 1'b1; seq_len_i = len[SW:0]; seq_loop_i = lp; seq_stop_i = with_stop;
    if (!with_stop && len != 0 && !m_run) begin
      m_len = (len > NSEG) ? NSEG : len;
      m_loop = lp; m_run = 1'b1; m_played = 0;
      m_nx = 2 % m_len;
      push(K_BUSY, k + 1, 1);
      if (m_pl != 0) push(K_IDX, k + 1, 0);
      m_pl = 0;
      if (m_werr) push(K_WERR, k, 0);
      m_werr = 1'b0;
      set_bank(0, m_tbl[0], k + 2);
      set_bank(1, m_tbl[1 % m_len], k + 3);
      push(K_RST, k + 4, 0);
      push(K_TRIG, k + 4, 1);
      push(K_TRIG, k + 5, 0);
    end
    tick();
    seq_start_i = 1'b0; seq_stop_i = 1'b0;
  endtask

  task automatic do_stop();
    int s;
    s = cyc + 1;
    seq_stop_i = 1'b1;
    if (m_run) begin
      push(K_RST, s + 1, 1);
      push(K_BUSY, s + 1, 0);
      m_run = 1'b0;
    end
    tick();
    seq_stop_i = 1'b0;
  endtask

  // Channel switches bank: the bank it leaves gets the next descriptor.
  task automatic flip();
    int  t;
    bit  old;
    t = cyc + 1;
    old = ch_buf_i;
    ch_buf_i = ~ch_buf_i;
    if (m_run) begin
      m_played++;
      if (!m_loop && m_played == m_len) begin
        push(K_DONE, t + 1, 1);
        push(K_DONE, t + 2, 0);
        push(K_RST, t + 1, 1);
        push(K_BUSY, t + 1, 0);
        m_run = 1'b0;
      end else begin
        if ((m_pl + 1) % m_len != m_pl) push(K_IDX, t + 1, (m_pl + 1) % m_len);
        m_pl = (m_pl + 1) % m_len;
        set_bank(int'(old), m_tbl[m_nx], t + 2);
        m_nx = (m_nx + 1) % m_len;
      end
    end
    tick();
  endtask

  task automatic flips(int n);
    for (int i = 0; i < n; i++) begin
      wait_n($urandom_range(6, 25));
      flip();
    end
  endtask

  task automatic do_reset(string tag);
    mon_en = 1'b0;
    dac_rst_i = 1'b1;
    tick();
    dac_rst_i = 1'b0;
    chk({tag, " bank0"}, bank0_o, '0);
    chk({tag, " bank1"}, bank1_o, '0);
    chk({tag, " ch_rst"}, DW'(ch_rst_o), DW'(1));
    chk({tag, " ch_trig"}, DW'(ch_trig_o), '0);
    chk({tag, " busy"}, DW'(seq_busy_o), '0);
    chk({tag, " seq_idx"}, DW'(seq_idx_o), '0);
    chk({tag, " done"}, DW'(seq_done_o), '0);
    chk({tag, " werr"}, DW'(seq_werr_o), '0);
    expq.delete();
    m_bank[0] = '0; m_bank[1] = '0;
    m_run = 1'b0; m_werr = 1'b0; m_pl = 0;
    tick();
    mon_en = 1'b1;
  endtask

  task automatic end_check(string tag);
    wait_n(8);
    check_empty(tag);
    chk({tag, " bank0"}, bank0_o, m_bank[0]);
    chk({tag, " bank1"}, bank1_o, m_bank[1]);
    chk({tag, " busy"}, DW'(seq_busy_o), DW'(m_run));
    chk({tag, " ch_rst"}, DW'(ch_rst_o), DW'(!m_run));
  endtask

  initial begin
    logic [DW-1:0] d;
    int len, nf;
    bit lp;
    m_run = 1'b0; m_werr = 1'b0; m_pl = 0;
    for (int i = 0; i < NSEG; i++) m_tbl[i] = '0;
    wait_n(3);
    do_reset("reset");

    // Write and prime, then play a 3-segment chain once.
    for (int i = 0; i < 3; i++) begin
      d = rnd_desc();
      d[DW-1 -: 14] = 14'h1000 >> i;
      wr(i, d);
    end
    do_start(3, 1'b0, 1'b0);
    flips(3);
    end_check("chain");

    // Looped 3-segment chain: no completion, stopped by software.
    do_start(3, 1'b1, 1'b0);
    flips(10);
    wait_n(8);
    do_stop();
    end_check("loop");

    // Single-segment chain: both banks hold desc0.
    do_start(1, 1'b0, 1'b0);
    wait_n(8);
    chk("len1 bank0", bank0_o, m_tbl[0]);
    chk("len1 bank1", bank1_o, m_tbl[0]);
    flips(1);
    end_check("len1");

    // Zero-length start and start+stop together are both ignored.
    do_start(0, 1'b0, 1'b0);
    end_check("len0");
    do_start(3, 1'b0, 1'b1);
    end_check("startstop");

    // Full table, length above NSEG clamps and wraps 7 -> 0.
    for (int i = 0; i < NSEG; i++) wr(i, rnd_desc());
    do_start(9, 1'b1, 1'b0);
    flips(11);
    wait_n(8);
    do_stop();
    end_check("len9");

    // Write during RUN is rejected and flagged; next start clears the flag.
    do_start(3, 1'b0, 1'b0);
    wait_n(8);
    wr(0, rnd_desc());
    tick();
    chk("werr set", DW'(seq_werr_o), DW'(1));
    flips(3);
    end_check("werr");
    do_start(4, 1'b0, 1'b0);
    wait_n(8);
    chk("werr cleared", DW'(seq_werr_o), '0);
    chk("table kept", bank0_o, m_tbl[0]);
    flips(1);
    wait_n(10);
    do_stop();
    end_check("stop");

    // Reset mid-run, then replay from the retained table.
    do_start(5, 1'b1, 1'b0);
    flips(2);
    wait_n(5);
    do_reset("midreset");
    do_start(5, 1'b0, 1'b0);
    flips(5);
    end_check("replay");

    // Randomized chains.
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 1) == 1) wr($urandom_range(0, NSEG - 1), rnd_desc());
      len = $urandom_range(1, 9);
      lp  = 1'($urandom_range(0, 1));
      nf  = lp ? $urandom_range(1, 12) : $urandom_range(0, (len > NSEG) ? NSEG : len);
      do_start(len, lp, 1'b0);
      wait_n(6);
      flips(nf);
      wait_n(8);
      if (m_run) do_stop();
      end_check("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/red_pitaya_asg_seq.md
# red_pitaya_asg_seq

Segment sequencer for one double-buffered ASG channel. It holds a software-programmed table of up to NSEG waveform segment descriptors and primes both of the channel's configuration banks. It then refills whichever bank the channel vacates at each bank switch, so that arbitrary segment chains play back-to-back, once or looped. It sits between the register bus and the channel's `set_*_all_i` inputs; it drives the channel's reset and software trigger and observes the channel's `current_buf`.

## Interface
- `RSZ`, 14: buffer address width of the channel.
- `NSEG`, 8: descriptor table depth (power of two, ≥2).
- `SW`, 3: log2(NSEG).
- `DW`, 44+3*(RSZ+16): descriptor width. LSB-first packing is ncyc[16], ofs[RSZ+16], step[RSZ+16], size[RSZ+16], dc[14], amp[14].

Ports:
- `dac_clk_i`  in  1  sole clock.
- `dac_rst_i`  in  1  synchronous, active-high reset.
- `seg_we_i`  in  1  table write strobe.
- `seg_idx_i`  in  SW  table entry index.
- `seg_desc_i`  in  DW  descriptor to write.
- `seq_start_i`  in  1  start pulse.
- `seq_stop_i`  in  1  stop pulse.
- `seq_len_i`  in  SW+1  segment count, 1..NSEG.
- `seq_loop_i`  in  1  loop the chain forever.
- `ch_buf_i`  in  1  channel's active bank (current_buf).
- `bank0_o`  out  DW  config for channel bank 0.
- `bank1_o`  out  DW  config for channel bank 1.
- `ch_rst_o`  out  1  channel set_rst.
- `ch_trig_o`  out  1  channel software trigger pulse.
- `seq_busy_o`  out  1  sequence active.
- `seq_idx_o`  out  SW  index of the segment currently playing.
- `seq_done_o`  out  1  one-cycle pulse when a non-loop chain completes.
- `seq_werr_o`  out  1  sticky flag: table write attempted while busy.

## Operation
- Table: NSEG×DW storage with 1-cycle synchronous read.
  - A write occurs when `seg_we_i` is high and the FSM is in IDLE.
  - Any write attempt outside IDLE is discarded and sets `seq_werr_o`.
  - `seq_werr_o` is cleared by reset or by an accepted start.
- All outputs are registered.
- Reset values: banks 0, `ch_rst_o`=1, `ch_trig_o`=0, `seq_busy_o`=0, `seq_idx_o`=0, `seq_done_o`=0, `seq_werr_o`=0, state IDLE.
- `ch_buf_q` is a register of `ch_buf_i`, updated every cycle. `toggle` = `ch_buf_i` ^ `ch_buf_q`.
- FSM states: IDLE, PRIME0, PRIME1, ARM, RUN.
  - **IDLE:** `ch_rst_o`=1.
    - `seq_start_i` with `seq_len_i`≠0 latches len. Len values above NSEG clamp to NSEG.
    - It also latches loop, sets read address 0, clears play_idx and played count, and goes to PRIME0.
    - `seq_len_i`=0 ignores the start.
  - **PRIME0:** `bank0_o` ← tbl[0]; read address ← 1 mod len; go to PRIME1.
  - **PRIME1:** `bank1_o` ← tbl[1 mod len]; ld_idx ← 2 mod len; go to ARM.
  - **ARM:** `ch_rst_o` ← 0, `ch_trig_o` ← 1 for exactly one cycle; go to RUN.
  - **RUN:** on `toggle`, played increments.
    - If !loop and played+1 == len: `ch_rst_o` ← 1, `seq_done_o` pulse, go to IDLE.
    - Otherwise: the vacated bank (index `ch_buf_q`) ← tbl[ld_idx], ld_idx ← (ld_idx+1) mod len, play_idx ← (play_idx+1) mod len.
- Index increments wrap when idx+1 == len, not at NSEG.
- len=1 loads the same descriptor into both banks.
- Loop mode never asserts `seq_done_o`. The played counter saturates and is ignored in loop mode.
- `seq_stop_i` in any non-IDLE state: next state IDLE, `ch_rst_o`=1, banks retain their values, no `seq_done_o`.
- Event priority: reset > stop > start. Start while busy is ignored. Stop and start in the same IDLE cycle: stop wins, so the chain stays idle.
- `toggle` is ignored outside RUN.

## Timing
- Start sampled at edge k:
  - `seq_busy_o`=1 after edge k+1.
  - `bank0_o` valid after edge k+2.
  - `bank1_o` valid after edge k+3.
  - After edge k+4: `ch_rst_o`=0 and `ch_trig_o`=1 for one cycle.
- Toggle at edge t:
  - `seq_idx_o` updates after edge t+1.
  - The vacated bank is rewritten after edge t+2.
  - The vacated bank is unused by the channel until its next switch, so segments must last ≥4 cycles.
- Completion at toggle edge t: `ch_rst_o`=1, `seq_busy_o`=0 and `seq_done_o`=1 after edge t+1. `seq_done_o` clears after edge t+2.
  - The channel may output up to 2 samples of the other bank before its reset takes effect; this is accepted behaviour.
- Stop at edge s: `ch_rst_o`=1 and `seq_busy_o`=0 after edge s+1.
- Reset mid-sequence: every output returns to its reset value after the reset edge, and the table contents are retained.

## Test plan
- **Write and prime:** write 3 distinct descriptors (amp=0x1000/0x0800/0x0400), len=3, loop=0, start.
  - Expect `bank0_o`=desc0 and `bank1_o`=desc1 at k+2/k+3, then a single `ch_trig_o` pulse at k+4.
- **Chain progression:** model `ch_buf_i` toggling every 20 cycles.
  - Expect `seq_idx_o` 0→1→2; bank0 reloaded with desc2 after the first toggle.
  - Expect `seq_done_o` pulse and `ch_rst_o`=1 one cycle after the 3rd toggle.
- **Loop wrap:** len=3, loop=1, 10 toggles.
  - Expect reload order desc2, desc0, desc1, …, `seq_idx_o` sequence 1,2,0,1,…, and no `seq_done_o`.
- **len=1 and boundary values:** len=1 gives identical banks; len=0 start gives no response.
  - len=9 with NSEG=8 behaves as len=8 (indices wrap 7→0).
- **Conflicts:** write during RUN leaves the table unchanged and sets `seq_werr_o`=1, which the next start clears.
  - Start+stop in the same IDLE cycle stays IDLE.
  - Stop during RUN gives `ch_rst_o`=1 at s+1 with banks unchanged.
- **Reset mid-RUN:** assert `dac_rst_i` for 1 cycle.
  - All outputs return to reset values; a subsequent start replays from desc0 using the retained table.
